// File: rtl/event_timestamp_fifo_pkg.sv
// Shared defaults for the event timestamp FIFO so that readout-side decode and the block agree.
// No logic here, so there is no latency.
// No flow control here.
package event_timestamp_fifo_pkg;

    // Width of the free-running timestamp and of each queued stamp
    localparam int TS_WIDTH_DEF   = 16;
    // log2 of the FIFO depth (4 entries by default)
    localparam int DEPTH_LOG2_DEF = 2;
    // Width of the saturating dropped-event counter
    localparam int OVF_WIDTH_DEF  = 8;

endpackage

// File: rtl/sync_fifo_regs.sv
// Register-array FIFO with a registered head entry and a level counter.
// A push into an empty FIFO is visible at the head one cycle later; there is no fall-through.
// The caller qualifies push against full; pop is ignored while the head is not valid.
module sync_fifo_regs #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [WIDTH-1:0]      head_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic [DEPTH_LOG2:0]   level_next;
    logic [DEPTH_LOG2:0]   remain;
    logic [WIDTH-1:0]      head_next;
    logic                  pop_ok;
    logic                  push_ok;

    // Full and empty come from the level counter; pointers simply wrap
    assign full    = (level == FULL_LEVEL);
    assign pop_ok  = pop && head_valid;
    assign push_ok = push && (!full || pop_ok);

    // Next pointer, next level and the entry that becomes the registered head
    always_comb begin
        rd_ptr_next = pop_ok ? rd_ptr + PTR_ONE : rd_ptr;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + LVL_ONE;
            2'b01:   level_next = level - LVL_ONE;
            default: level_next = level;
        endcase
        // Entries still held once this cycle's pop is taken out
        remain    = pop_ok ? level - LVL_ONE : level;
        head_next = head_data;
        if (remain != '0) begin
            head_next = mem[rd_ptr_next];
        end else if (push_ok) begin
            head_next = push_data;
        end
    end

    // Pointer, level and head registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr     <= rd_ptr_next;
            level      <= level_next;
            head_valid <= (level_next != '0);
            head_data  <= head_next;
        end
    end

    // Storage array; contents are meaningless until covered by the level
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/event_timestamp_fifo.sv
// Stamps synchronised event pulses with a free-running counter and queues the stamps.
// A stamp is presented on evt_valid/evt_ts one cycle after its event; the head holds until taken.
// When full, an event is accepted only alongside a pop; otherwise it is dropped and counted.
module event_timestamp_fifo
    import event_timestamp_fifo_pkg::*;
#(
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int OVF_WIDTH  = OVF_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  event_in,
    input  logic                  ts_clear,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [TS_WIDTH-1:0]   evt_ts,
    output logic [DEPTH_LOG2:0]   evt_level,
    output logic [OVF_WIDTH-1:0]  ovf_count,
    input  logic                  ovf_clear
);

    localparam logic [TS_WIDTH-1:0]  TS_ONE  = TS_WIDTH'(1);
    localparam logic [OVF_WIDTH-1:0] OVF_ONE = OVF_WIDTH'(1);

    logic [TS_WIDTH-1:0] ts;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                drop;

    // A pop frees a slot in the same cycle, so a full FIFO still takes the event
    assign pop  = evt_valid && evt_ready;
    assign push = event_in && (!fifo_full || pop);
    assign drop = event_in && fifo_full && !pop;

    // Free-running timestamp; the stamp captured this cycle is the pre-clear value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else if (ts_clear) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_ONE;
        end
    end

    // Saturating count of dropped events; a drop during clear leaves a count of one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (ovf_clear) begin
            ovf_count <= drop ? OVF_ONE : '0;
        end else if (drop && (ovf_count != '1)) begin
            ovf_count <= ovf_count + OVF_ONE;
        end
    end

    sync_fifo_regs #(
        .WIDTH      (TS_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (ts),
        .pop        (pop),
        .head_valid (evt_valid),
        .head_data  (evt_ts),
        .level      (evt_level),
        .full       (fifo_full)
    );

endmodule
